// File: rtl/coax_rx_bit_timer_if.sv
// Coax RX line and restart control in; recovered bit timing strobes out.
// slave = bit timer side, master = line driver / word deserializer side.
interface coax_rx_bit_timer_if;
  logic rx;
  logic clear;
  logic locked;
  logic first_sample;
  logic second_sample;
  logic bit_strobe;
  logic bit_value;
  logic error;

  modport slave (
    input  rx, clear,
    output locked, first_sample, second_sample, bit_strobe, bit_value, error
  );

  modport master (
    output rx, clear,
    input  locked, first_sample, second_sample, bit_strobe, bit_value, error
  );
endinterface

// File: rtl/coax_rx_bit_timer.sv
// Biphase coax RX bit timer: locks on first edge, resyncs on mid-bit edges (COAX_RX_BIT_TIMER_DEGLITCH_EN adds a 2-sample rx filter).
// Latency: edge acts on the next cycle's count (+1 clk with the filter); strobes decode from registered state.
// Backpressure: none; strobes free-run while locked, clear restarts to IDLE on the next cycle.
module coax_rx_bit_timer #(
  parameter int CLOCKS_PER_BIT = 8,
  parameter int TOLERANCE      = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  coax_rx_bit_timer_if.slave bus
);

  localparam int HALF    = CLOCKS_PER_BIT / 2;
  localparam int QUARTER = CLOCKS_PER_BIT / 4;
  localparam int CW      = $clog2(CLOCKS_PER_BIT);

  localparam logic [CW-1:0] C_QTR    = CW'(QUARTER);
  localparam logic [CW-1:0] C_3QTR   = CW'(3 * QUARTER);
  localparam logic [CW-1:0] C_LAST   = CW'(CLOCKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_RESYNC = CW'(HALF + 1);
  localparam logic [CW-1:0] C_WIN_LO = CW'(HALF - TOLERANCE);
  localparam logic [CW-1:0] C_WIN_HI = CW'(HALF + TOLERANCE);
  localparam logic [CW-1:0] C_BND_LO = CW'(TOLERANCE);
  localparam logic [CW-1:0] C_BND_HI = CW'(CLOCKS_PER_BIT - TOLERANCE);

  typedef enum logic {S_IDLE = 1'b0, S_LOCKED = 1'b1} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt, w_cnt_adv;
  logic          r_primed, w_primed_nxt;
  logic          r_mid_seen, w_mid_nxt;
  logic          r_block, w_block_nxt;
  logic          r_prev_valid, r_rx_prev, r_bit_value;
  logic          w_rx, w_edge, w_in_win, w_at_bnd, w_error, w_strobe_en;

`ifdef COAX_RX_BIT_TIMER_DEGLITCH_EN
  logic r_rx_filt, r_pend;

  // First sample after reset seeds the filter so a static line is not seen as an edge.
  assign w_rx = !r_prev_valid ? bus.rx
              : ((bus.rx != r_rx_filt) && r_pend) ? bus.rx : r_rx_filt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_filt <= 1'b0;
      r_pend    <= 1'b0;
    end else begin
      r_rx_filt <= w_rx;
      r_pend    <= (bus.rx != w_rx);
    end
  end
`else
  assign w_rx = bus.rx;
`endif

  assign w_edge    = r_prev_valid & (w_rx ^ r_rx_prev);
  assign w_in_win  = (r_cnt >= C_WIN_LO) && (r_cnt <= C_WIN_HI);
  assign w_at_bnd  = (r_cnt <= C_BND_LO) || (r_cnt >= C_BND_HI);
  assign w_cnt_adv = (r_cnt == C_LAST) ? '0 : r_cnt + CW'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_primed     <= 1'b0;
      r_mid_seen   <= 1'b0;
      r_block      <= 1'b0;
      r_prev_valid <= 1'b0;
      r_rx_prev    <= 1'b0;
      r_bit_value  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_primed     <= w_primed_nxt;
      r_mid_seen   <= w_mid_nxt;
      r_block      <= w_block_nxt;
      r_prev_valid <= 1'b1;
      r_rx_prev    <= w_rx;
      if (bus.first_sample) begin
        r_bit_value <= w_rx;
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_primed_nxt = r_primed;
    w_mid_nxt    = r_mid_seen;
    w_block_nxt  = 1'b0;
    w_error      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt    = '0;
        w_primed_nxt = 1'b0;
        w_mid_nxt    = 1'b0;
        // The first edge seen is treated as a mid-bit edge.
        if (w_edge && !bus.clear && !r_block) begin
          w_state_nxt = S_LOCKED;
          w_cnt_nxt   = C_RESYNC;
          w_mid_nxt   = 1'b1;
        end
      end
      S_LOCKED: begin
        if (bus.clear) begin
          w_state_nxt  = S_IDLE;
          w_cnt_nxt    = '0;
          w_primed_nxt = 1'b0;
          w_mid_nxt    = 1'b0;
        end else if (w_edge && w_in_win) begin
          w_cnt_nxt = C_RESYNC;
          w_mid_nxt = 1'b1;
        end else if ((w_edge && !w_at_bnd) ||
                     (!w_edge && !r_mid_seen && (r_cnt == C_WIN_HI))) begin
          w_error      = 1'b1;
          w_state_nxt  = S_IDLE;
          w_cnt_nxt    = '0;
          w_primed_nxt = 1'b0;
          w_mid_nxt    = 1'b0;
          w_block_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = w_cnt_adv;
          if (r_cnt == C_LAST) begin
            w_primed_nxt = 1'b1;
            w_mid_nxt    = 1'b0;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    w_strobe_en       = (r_state == S_LOCKED) && r_primed;
    bus.locked        = (r_state == S_LOCKED);
    bus.first_sample  = w_strobe_en && (r_cnt == C_QTR);
    bus.second_sample = w_strobe_en && (r_cnt == C_3QTR);
    bus.bit_strobe    = w_strobe_en && (r_cnt == C_LAST);
    bus.bit_value     = r_bit_value;
    bus.error         = w_error;
  end

endmodule

// File: tb/tb_coax_rx_bit_timer.sv
// Self-checking bench for coax_rx_bit_timer: directed scenarios plus randomized line traffic
// against a cycle-level behavioural model of the bit timer.
module tb_coax_rx_bit_timer;
  localparam int CPB  = 8;
  localparam int TOL  = 1;
  localparam int HALF = CPB / 2;
  localparam int QTR  = CPB / 4;
`ifdef COAX_RX_BIT_TIMER_DEGLITCH_EN
  localparam int DLY = 1;
`else
  localparam int DLY = 0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic rst_req = 1'b0;
  int   checks = 0;
  int   errors = 0;

  coax_rx_bit_timer_if bus();

  coax_rx_bit_timer #(.CLOCKS_PER_BIT(CPB), .TOLERANCE(TOL)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  logic o_locked, o_first, o_second, o_strobe, o_bv, o_err;
  logic e_locked, e_first, e_second, e_strobe, e_bv, e_err;

  // Behavioural model: phase counts clocks since the bit boundary.
  logic m_locked, m_primed, m_mid, m_failed, m_pv, m_prev, m_filt, m_rawprev, m_bv;
  int   m_phase;

  logic wave[$];

  task automatic model_reset();
    m_locked = 0; m_primed = 0; m_mid = 0; m_failed = 0; m_pv = 0;
    m_prev = 0; m_filt = 0; m_rawprev = 0; m_bv = 0; m_phase = 0;
  endtask

  task automatic model_fail();
    e_err = 1; m_locked = 0; m_phase = 0; m_primed = 0; m_failed = 1;
  endtask

  task automatic model_step(input logic rxv, input logic clr);
    logic eff, edg, was_failed;
    if (!reset_n) begin
      model_reset();
      {e_locked, e_first, e_second, e_strobe, e_bv, e_err} = '0;
      return;
    end
    eff = rxv;
    if (DLY == 1 && m_pv)
      eff = (rxv != m_filt && m_rawprev != m_filt) ? rxv : m_filt;
    edg = m_pv && (eff != m_prev);
    e_locked = m_locked;
    e_first  = m_locked && m_primed && m_phase == QTR;
    e_second = m_locked && m_primed && m_phase == 3 * QTR;
    e_strobe = m_locked && m_primed && m_phase == CPB - 1;
    e_bv     = m_bv;
    e_err    = 0;
    if (e_first) m_bv = eff;
    was_failed = m_failed;
    m_failed = 0;
    if (!m_locked) begin
      if (edg && !clr && !was_failed) begin
        m_locked = 1; m_phase = HALF + 1; m_primed = 0; m_mid = 1;
      end
    end else if (clr) begin
      m_locked = 0; m_phase = 0; m_primed = 0;
    end else if (edg && (m_phase - HALF) <= TOL && (HALF - m_phase) <= TOL) begin
      m_phase = HALF + 1; m_mid = 1;
    end else if (edg && !(m_phase <= TOL || m_phase >= CPB - TOL)) begin
      model_fail();
    end else if (!edg && !m_mid && m_phase == HALF + TOL) begin
      model_fail();
    end else begin
      m_phase++;
      if (m_phase == CPB) begin
        m_phase = 0; m_primed = 1; m_mid = 0;
      end
    end
    m_pv = 1; m_prev = eff; m_filt = eff; m_rawprev = rxv;
  endtask

  task automatic cycle(input logic rxv, input logic clr);
    @(posedge clk);
    #1;
    reset_n = rst_req;
    bus.rx = rxv;
    bus.clear = clr;
    #1;
    o_locked = bus.locked; o_first = bus.first_sample; o_second = bus.second_sample;
    o_strobe = bus.bit_strobe; o_bv = bus.bit_value; o_err = bus.error;
    model_step(rxv, clr);
  endtask

  task automatic apply_reset();
    rst_req = 0;
    repeat (2) cycle(1'b1, 1'b0);
    rst_req = 1;
  endtask

  task automatic add_bit(input logic b, input int off);
    for (int k = 0; k < HALF + off; k++) wave.push_back(b);
    for (int k = 0; k < HALF - off; k++) wave.push_back(~b);
  endtask

  task automatic add_level(input logic lvl, input int n);
    for (int k = 0; k < n; k++) wave.push_back(lvl);
  endtask

  task automatic test_reset();
    rst_req = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'(i % 2), 1'b0);
      checks++;
      if ({o_locked, o_first, o_second, o_strobe, o_bv, o_err} !== 6'b0) begin
        errors++;
        $display("FAIL reset_outputs cyc %0d got %b want 000000", i,
                 {o_locked, o_first, o_second, o_strobe, o_bv, o_err});
      end
    end
    rst_req = 1;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0);
      checks++;
      if (o_locked !== 1'b0 || o_err !== 1'b0) begin
        errors++;
        $display("FAIL reset_static_idle cyc %0d got locked=%b err=%b want 0 0", i, o_locked, o_err);
      end
    end
  endtask

  // Runs the 1,0,1,1 stream with per-bit mid-edge offsets and checks strobe timing.
  task automatic run_stream(input string nm, input int off2, input int exp_s0,
                            input int exp_s1, input int exp_s2);
    int st[$]; logic bv[$]; int nf, ns, ne; logic lk_pre, lk_post;
    int exp_st[3]; logic exp_bv[3];
    nf = 0; ns = 0; ne = 0; lk_pre = 1'bx; lk_post = 1'bx;
    exp_st = '{exp_s0, exp_s1, exp_s2};
    exp_bv = '{1'b0, 1'b1, 1'b1};
    apply_reset();
    wave.delete();
    add_bit(1, 0); add_bit(0, 0); add_bit(1, off2); add_bit(1, 0);
    add_level(1'b0, 1 + DLY);
    for (int i = 0; i < wave.size(); i++) begin
      cycle(wave[i], 1'b0);
      if (o_strobe) begin st.push_back(i); bv.push_back(o_bv); end
      nf += int'(o_first); ns += int'(o_second); ne += int'(o_err);
      if (i == 4 + DLY) lk_pre = o_locked;
      if (i == 5 + DLY) lk_post = o_locked;
    end
    cycle(1'b0, 1'b1);
    checks++;
    if (lk_pre !== 1'b0) begin errors++; $display("FAIL %s locked_at_edge got %b want 0", nm, lk_pre); end
    checks++;
    if (lk_post !== 1'b1) begin errors++; $display("FAIL %s locked_after_edge got %b want 1", nm, lk_post); end
    checks++;
    if (st.size() != 3) begin errors++; $display("FAIL %s strobe_count got %0d want 3", nm, st.size()); end
    for (int k = 0; k < 3 && k < st.size(); k++) begin
      checks++;
      if (st[k] != exp_st[k]) begin
        errors++; $display("FAIL %s strobe_pos[%0d] got %0d want %0d", nm, k, st[k], exp_st[k]);
      end
      checks++;
      if (bv[k] !== exp_bv[k]) begin
        errors++; $display("FAIL %s bit_value[%0d] got %b want %b", nm, k, bv[k], exp_bv[k]);
      end
    end
    checks++;
    if (nf != 3 || ns != 3) begin
      errors++; $display("FAIL %s sample_counts got %0d/%0d want 3/3", nm, nf, ns);
    end
    checks++;
    if (ne != 0) begin errors++; $display("FAIL %s error_count got %0d want 0", nm, ne); end
  endtask

  task automatic test_lock_bits();
    run_stream("lock_bits", 0, 15 + DLY, 23 + DLY, 31 + DLY);
  endtask

  task automatic test_jitter();
    // Bit 2 mid edge one clock late: strobe gaps 9 then 7.
    run_stream("jitter", 1, 15 + DLY, 24 + DLY, 31 + DLY);
  endtask

  task automatic test_bad_edge();
    int ne, err_at; logic lk[4];
    ne = 0; err_at = -1;
    apply_reset();
    wave.delete();
    add_bit(1, 0); add_bit(0, 0); add_level(1'b1, 2);
    if (DLY == 0) begin
      add_level(1'b0, 1); add_level(1'b1, 4); add_level(1'b0, 5);
    end else begin
      add_level(1'b0, 5); add_level(1'b1, 5);
    end
    for (int i = 0; i < wave.size(); i++) begin
      cycle(wave[i], 1'b0);
      if (o_err) begin ne++; err_at = i; end
      if (i == 18 + DLY) lk[0] = o_locked;
      if (i == 19 + DLY) lk[1] = o_locked;
      if (i == 20 + DLY) lk[2] = o_locked;
      if (i == 24 + DLY) lk[3] = o_locked;
    end
    checks++;
    if (ne != 1 || err_at != 18 + DLY) begin
      errors++; $display("FAIL bad_edge_error got n=%0d at %0d want n=1 at %0d", ne, err_at, 18 + DLY);
    end
    checks++;
    if (lk[0] !== 1'b1 || lk[1] !== 1'b0) begin
      errors++; $display("FAIL bad_edge_unlock got %b%b want 10", lk[0], lk[1]);
    end
    checks++;
    if (lk[2] !== 1'b0) begin errors++; $display("FAIL bad_edge_blocked_relock got %b want 0", lk[2]); end
    checks++;
    if (lk[3] !== 1'b1) begin errors++; $display("FAIL bad_edge_relock got %b want 1", lk[3]); end
  endtask

  task automatic test_missing_mid();
    int ne, err_at, nst, st0; logic lk;
    ne = 0; err_at = -1; nst = 0; st0 = -1; lk = 1'bx;
    apply_reset();
    wave.delete();
    add_bit(1, 0); add_bit(0, 0); add_level(1'b1, 12);
    for (int i = 0; i < wave.size(); i++) begin
      cycle(wave[i], 1'b0);
      if (o_err) begin ne++; err_at = i; end
      if (o_strobe) begin nst++; if (st0 < 0) st0 = i; end
      if (i == 22 + DLY) lk = o_locked;
    end
    checks++;
    if (ne != 1 || err_at != 21 + DLY) begin
      errors++; $display("FAIL missing_mid_error got n=%0d at %0d want n=1 at %0d", ne, err_at, 21 + DLY);
    end
    checks++;
    if (lk !== 1'b0) begin errors++; $display("FAIL missing_mid_unlock got %b want 0", lk); end
    checks++;
    if (nst != 1 || st0 != 15 + DLY) begin
      errors++; $display("FAIL missing_mid_strobes got n=%0d first %0d want n=1 at %0d", nst, st0, 15 + DLY);
    end
  endtask

  task automatic test_clear_and_pulse();
    int ne, nst_after, nlk; logic lk_a, lk_b, lk_p;
    ne = 0; nst_after = 0; nlk = 0;
    apply_reset();
    wave.delete();
    add_bit(1, 0); add_bit(0, 0); add_level(1'b1, 14);
    for (int i = 0; i < wave.size(); i++) begin
      cycle(wave[i], 1'(i == 19 + DLY));
      ne += int'(o_err);
      if (i > 19 + DLY) nst_after += int'(o_strobe | o_first | o_second);
      if (i == 19 + DLY) lk_a = o_locked;
      if (i == 20 + DLY) lk_b = o_locked;
    end
    checks++;
    if (lk_a !== 1'b1 || lk_b !== 1'b0) begin
      errors++; $display("FAIL clear_unlock got %b%b want 10", lk_a, lk_b);
    end
    checks++;
    if (ne != 0 || nst_after != 0) begin
      errors++; $display("FAIL clear_quiet got err=%0d strobes=%0d want 0 0", ne, nst_after);
    end
    for (int j = 0; j < 8; j++) begin
      cycle(1'(j != 3), 1'b0);
      nlk += int'(o_locked);
      if (j == 4) lk_p = o_locked;
    end
    checks++;
    if (lk_p !== 1'(DLY == 0)) begin
      errors++; $display("FAIL pulse_lock got %b want %b", lk_p, 1'(DLY == 0));
    end
    checks++;
    if (nlk != ((DLY == 0) ? 4 : 0)) begin
      errors++; $display("FAIL pulse_locked_cycles got %0d want %0d", nlk, (DLY == 0) ? 4 : 0);
    end
  endtask

  task automatic test_random();
    logic b, lvl, rxv, held, clr;
    int pos, mid, hold, r;
    b = 1; pos = 0; mid = HALF; hold = 0; held = 1;
    apply_reset();
    for (int i = 0; i < 4000; i++) begin
      lvl = (pos < mid) ? b : ~b;
      rxv = lvl;
      if ($urandom_range(0, 59) == 0) rxv = ~lvl;
      if (hold > 0) begin
        hold--; rxv = held;
      end else if ($urandom_range(0, 249) == 0) begin
        hold = 12; held = rxv;
      end
      clr = ($urandom_range(0, 79) == 0);
      rst_req = ($urandom_range(0, 999) != 0);
      cycle(rxv, clr);
      checks++;
      if ({o_locked, o_first, o_second, o_strobe, o_bv, o_err} !==
          {e_locked, e_first, e_second, e_strobe, e_bv, e_err}) begin
        errors++;
        $display("FAIL random cyc %0d got lk/fs/ss/bs/bv/err=%b want %b", i,
                 {o_locked, o_first, o_second, o_strobe, o_bv, o_err},
                 {e_locked, e_first, e_second, e_strobe, e_bv, e_err});
      end
      pos++;
      if (pos == CPB) begin
        pos = 0;
        b = 1'($urandom_range(0, 1));
        r = int'($urandom_range(0, 19));
        mid = HALF + ((r == 0) ? 2 : int'($urandom_range(0, 2)) - 1);
      end
    end
    rst_req = 1;
  endtask

  initial begin
    bus.rx = 1'b1;
    bus.clear = 1'b0;
    model_reset();
    test_reset();
    test_lock_bits();
    test_jitter();
    test_bad_edge();
    test_missing_mid();
    test_clear_and_pulse();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
